// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back / PC-select sequencing controller.
// Drives the write-back stage's wb_sel/pc_sel selects, register-file write
// strobe and address. Holds off the memory stage while a load is outstanding,
// and flushes younger stages for FLUSH_CYCLES cycles after a redirect.
// Optional load-return timeout is built when WB_CTRL_TIMEOUT_EN is defined;
// without it LOAD_WAIT waits indefinitely and err_o is tied low.
module wb_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ins_valid_i,
    output logic       ins_ready_o,
    input  logic       is_load_i,
    input  logic       redirect_i,
    input  logic       rd_we_i,
    input  logic [4:0] rd_i,
    input  logic       mem_rvalid_i,
    output logic       wb_sel_o,
    output logic       pc_sel_o,
    output logic       rf_we_o,
    output logic [4:0] rf_rd_o,
    output logic       flush_o,
    output logic       err_o
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_LOAD_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH     = 2'd2;

    // Reject illegal parameter values at elaboration
    if (FLUSH_CYCLES == 0) begin : g_bad_flush
        $error("wb_ctrl: FLUSH_CYCLES must be >= 1");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("wb_ctrl: TIMEOUT must be >= 1");
    end

    logic [1:0]      state_q, state_d;
    logic            wb_sel_q, wb_sel_d;
    logic            pc_sel_q, pc_sel_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic            flush_q, flush_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            ld_we_q, ld_we_d;
    logic            accept;

`ifdef WB_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    // Accept only in RUN and never while reset is asserted
    assign ins_ready_o = (state_q == S_RUN) && rst;
    assign accept      = ins_valid_i && ins_ready_o;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        wb_sel_d    = wb_sel_q;
        pc_sel_d    = 1'b1;
        rf_we_d     = 1'b0;
        rf_rd_d     = rf_rd_q;
        flush_d     = 1'b0;
        flush_cnt_d = flush_cnt_q;
        ld_rd_d     = ld_rd_q;
        ld_we_d     = ld_we_q;
`ifdef WB_CTRL_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (is_load_i) begin
                        ld_rd_d = rd_i;
                        ld_we_d = rd_we_i;
                        state_d = S_LOAD_WAIT;
`ifdef WB_CTRL_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        wb_sel_d = 1'b1;
                        rf_rd_d  = rd_i;
                        rf_we_d  = rd_we_i && (rd_i != 5'd0);
                        if (redirect_i) begin
                            pc_sel_d    = 1'b0;
                            flush_d     = 1'b1;
                            flush_cnt_d = FC_W'(1);
                            state_d     = S_FLUSH;
                        end
                    end
                end
            end
            S_LOAD_WAIT: begin
                if (mem_rvalid_i) begin
                    wb_sel_d = 1'b0;
                    rf_rd_d  = ld_rd_q;
                    rf_we_d  = ld_we_q && (ld_rd_q != 5'd0);
                    state_d  = S_RUN;
`ifdef WB_CTRL_TIMEOUT_EN
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Last allowed wait cycle passed with no data: abandon load
                    err_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_RUN;
                end else if (to_cnt_q != TO_W'(TIMEOUT)) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FC_W'(FLUSH_CYCLES)) begin
                    flush_cnt_d = '0;
                    state_d     = S_RUN;
                end else begin
                    flush_d     = 1'b1;
                    flush_cnt_d = flush_cnt_q + FC_W'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            wb_sel_q    <= 1'b1;
            pc_sel_q    <= 1'b1;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= 5'd0;
            flush_q     <= 1'b0;
            flush_cnt_q <= '0;
            ld_rd_q     <= 5'd0;
            ld_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_sel_q    <= wb_sel_d;
            pc_sel_q    <= pc_sel_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            flush_q     <= flush_d;
            flush_cnt_q <= flush_cnt_d;
            ld_rd_q     <= ld_rd_d;
            ld_we_q     <= ld_we_d;
        end
    end

`ifdef WB_CTRL_TIMEOUT_EN
    // Load timeout counter and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign wb_sel_o = wb_sel_q;
    assign pc_sel_o = pc_sel_q;
    assign rf_we_o  = rf_we_q;
    assign rf_rd_o  = rf_rd_q;
    assign flush_o  = flush_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Scoreboard bench for wb_ctrl: the driver issues random instructions and
// pushes the expected write-back events / flush windows / error onset by cycle
// number; an independent monitor compares the DUT outputs every cycle.
module tb_wb_ctrl;

    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned TIMEOUT      = 4;
    localparam int          NONE         = 2147483647;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ins_valid_i, ins_ready_o, is_load_i, redirect_i, rd_we_i;
    logic [4:0] rd_i;
    logic       mem_rvalid_i;
    logic       wb_sel_o, pc_sel_o, rf_we_o, flush_o, err_o;
    logic [4:0] rf_rd_o;

    wb_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .ins_valid_i (ins_valid_i),
        .ins_ready_o (ins_ready_o),
        .is_load_i   (is_load_i),
        .redirect_i  (redirect_i),
        .rd_we_i     (rd_we_i),
        .rd_i        (rd_i),
        .mem_rvalid_i(mem_rvalid_i),
        .wb_sel_o    (wb_sel_o),
        .pc_sel_o    (pc_sel_o),
        .rf_we_o     (rf_we_o),
        .rf_rd_o     (rf_rd_o),
        .flush_o     (flush_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [4:0] rd;
        logic       wb;
        logic       we;
    } wr_t;

    wr_t wq[$];
    int  fq[$];
    int  err_from = NONE;
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare outputs each cycle against the scheduled expectations
    initial begin
        int         fstart;
        logic [4:0] last_rd;
        logic       last_wb;
        logic       exp_flush, exp_pc, exp_err;
        wr_t        e;
        fstart  = NONE;
        last_rd = 5'd0;
        last_wb = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fstart  = NONE;
                last_rd = 5'd0;
                last_wb = 1'b1;
            end else begin
                if (wq.size() > 0 && wq[0].at == cyc) begin
                    e = wq.pop_front();
                    check("rf_we", 32'(rf_we_o), 32'(e.we));
                    check("rf_rd", 32'(rf_rd_o), 32'(e.rd));
                    check("wb_sel", 32'(wb_sel_o), 32'(e.wb));
                    last_rd = e.rd;
                    last_wb = e.wb;
                end else begin
                    check("rf_we_idle", 32'(rf_we_o), 32'd0);
                    check("rf_rd_hold", 32'(rf_rd_o), 32'(last_rd));
                    check("wb_sel_hold", 32'(wb_sel_o), 32'(last_wb));
                end
                if (fq.size() > 0 && fq[0] == cyc) fstart = fq.pop_front();
                exp_flush = (fstart != NONE) && (cyc < fstart + int'(FLUSH_CYCLES));
                exp_pc    = (fstart != cyc);
                exp_err   = (cyc >= err_from);
                check("flush", 32'(flush_o), 32'(exp_flush));
                check("pc_sel", 32'(pc_sel_o), 32'(exp_pc));
                check("err", 32'(err_o), 32'(exp_err));
            end
        end
    end

    task automatic drive_junk(input logic rv);
        ins_valid_i  = 1'($urandom_range(0, 1));
        is_load_i    = 1'($urandom_range(0, 1));
        redirect_i   = 1'($urandom_range(0, 1));
        rd_we_i      = 1'($urandom_range(0, 1));
        rd_i         = 5'($urandom);
        mem_rvalid_i = rv;
    endtask

    task automatic set_idle();
        ins_valid_i  = 1'b0;
        is_load_i    = 1'b0;
        redirect_i   = 1'b0;
        rd_we_i      = 1'b0;
        rd_i         = 5'd0;
        mem_rvalid_i = 1'b0;
    endtask

    task automatic do_idle(input logic rv);
        check("ready_idle", 32'(ins_ready_o), 32'd1);
        set_idle();
        rd_i         = 5'($urandom);
        mem_rvalid_i = rv;
        @(negedge clk);
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic we, input logic redir);
        check("ready_alu", 32'(ins_ready_o), 32'd1);
        ins_valid_i  = 1'b1;
        is_load_i    = 1'b0;
        redirect_i   = redir;
        rd_we_i      = we;
        rd_i         = rd;
        mem_rvalid_i = 1'($urandom_range(0, 1));
        wq.push_back('{cyc + 1, rd, 1'b1, we && (rd != 5'd0)});
        if (redir) fq.push_back(cyc + 1);
        @(negedge clk);
        if (redir) begin
            for (int k = 0; k < int'(FLUSH_CYCLES); k++) begin
                check("ready_flush", 32'(ins_ready_o), 32'd0);
                drive_junk(1'($urandom_range(0, 1)));
                @(negedge clk);
            end
        end
    endtask

    // Load whose data returns d cycles after acceptance (or times out)
    task automatic do_load(input logic [4:0] rd, input logic we, input int d);
        int   n;
        int   nw;
        logic tmo;
        check("ready_load", 32'(ins_ready_o), 32'd1);
        ins_valid_i  = 1'b1;
        is_load_i    = 1'b1;
        redirect_i   = 1'($urandom_range(0, 1));
        rd_we_i      = we;
        rd_i         = rd;
        mem_rvalid_i = 1'b0;
        n   = cyc;
        tmo = 1'b0;
`ifdef WB_CTRL_TIMEOUT_EN
        tmo = (d > int'(TIMEOUT));
`endif
        if (tmo) begin
            if (err_from == NONE) err_from = n + int'(TIMEOUT) + 1;
            nw = int'(TIMEOUT);
        end else begin
            wq.push_back('{n + d + 1, rd, 1'b0, we && (rd != 5'd0)});
            nw = d;
        end
        @(negedge clk);
        for (int k = 1; k <= nw; k++) begin
            check("ready_wait", 32'(ins_ready_o), 32'd0);
            drive_junk(!tmo && (k == d));
            @(negedge clk);
        end
    endtask

    task automatic reset_mid_load();
        check("ready_rl", 32'(ins_ready_o), 32'd1);
        ins_valid_i  = 1'b1;
        is_load_i    = 1'b1;
        redirect_i   = 1'b0;
        rd_we_i      = 1'b1;
        rd_i         = 5'd9;
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        check("ready_rl_wait", 32'(ins_ready_o), 32'd0);
        drive_junk(1'b0);
        @(negedge clk);
        set_idle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_we", 32'(rf_we_o), 32'd0);
        check("rst_mid_rd", 32'(rf_rd_o), 32'd0);
        check("rst_mid_wb", 32'(wb_sel_o), 32'd1);
        check("rst_mid_pc", 32'(pc_sel_o), 32'd1);
        check("rst_mid_flush", 32'(flush_o), 32'd0);
        check("rst_mid_ready", 32'(ins_ready_o), 32'd0);
        wq.delete();
        fq.delete();
        err_from = NONE;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_idle(1'b1);
        do_idle(1'b0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Driver: directed cases first, then random traffic
    initial begin
        int r;
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        check("rst_we", 32'(rf_we_o), 32'd0);
        check("rst_rd", 32'(rf_rd_o), 32'd0);
        check("rst_wb", 32'(wb_sel_o), 32'd1);
        check("rst_pc", 32'(pc_sel_o), 32'd1);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_ready", 32'(ins_ready_o), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        do_alu(5'd5, 1'b1, 1'b0);
        do_alu(5'd0, 1'b1, 1'b0);
        do_load(5'd7, 1'b1, 3);
        do_alu(5'd3, 1'b1, 1'b1);
        do_idle(1'b1);
        do_load(5'd0, 1'b1, 1);
        do_alu(5'd8, 1'b0, 1'b0);
        reset_mid_load();
`ifdef WB_CTRL_TIMEOUT_EN
        do_load(5'd12, 1'b1, int'(TIMEOUT) + 2);
        do_alu(5'd4, 1'b1, 1'b0);
        do_load(5'd13, 1'b1, int'(TIMEOUT));
`endif

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)
                do_idle(1'($urandom_range(0, 1)));
            else if (r < 6)
                do_alu(5'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            else if (r < 9)
`ifdef WB_CTRL_TIMEOUT_EN
                do_load(5'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(1, TIMEOUT + 2)));
`else
                do_load(5'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
`endif
            else
                do_alu(5'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (4) do_idle(1'b0);
        check("queue_drain", 32'(wq.size() + fq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback/PC sequencing controller for the RISC-V core. It sits beside the write-back stage and issues that stage's `wb_sel`/`pc_sel` selects, register-file write enable and destination. It stalls the memory stage while a load is outstanding and flushes younger instructions after a taken branch or jump. It also guards load returns with an optional timeout.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `flush_o` stays high after a redirect; legal range ≥1.
- `TIMEOUT`, default 16: maximum wait for load data, in cycles; legal range ≥1; used only with the macro.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous reset, active-low.
- `ins_valid_i`  in  1  memory-stage instruction valid.
- `ins_ready_o`  out  1  controller accepts the instruction; retire happens on `ins_valid_i & ins_ready_o`.
- `is_load_i`  in  1  accepted instruction is a load.
- `redirect_i`  in  1  accepted instruction is a taken branch or jump.
- `rd_we_i`  in  1  instruction writes a register.
- `rd_i`  in  5  destination register.
- `mem_rvalid_i`  in  1  load data valid on the memory read port.
- `wb_sel_o`  out  1  1 selects the ALU result, 0 selects memory data.
- `pc_sel_o`  out  1  1 selects PC+4, 0 selects the write-back value (branch/jump target).
- `rf_we_o`  out  1  register-file write enable; one-cycle pulse.
- `rf_rd_o`  out  5  register-file write address.
- `flush_o`  out  1  kill younger pipeline stages.
- `err_o`  out  1  sticky load-timeout error.

## Operation
- FSM states: RUN, LOAD_WAIT, FLUSH. Reset state is RUN.
- `ins_ready_o` is combinational:
  - 1 only when the state is RUN and `rst` is high.
  - 0 in LOAD_WAIT and FLUSH.
- RUN, accepted non-load, no redirect:
  - Next cycle: `wb_sel_o`=1, `rf_rd_o`=`rd_i`, `rf_we_o`=`rd_we_i && rd_i!=0`.
  - State stays RUN.
- RUN, accepted non-load with `redirect_i`:
  - Write-back is the same as the no-redirect case.
  - Next cycle: `pc_sel_o`=0 and `flush_o`=1; state moves to FLUSH.
- RUN, accepted load:
  - `rd_i` and `rd_we_i` are latched; state moves to LOAD_WAIT.
  - `redirect_i` is ignored for loads.
- LOAD_WAIT:
  - When `mem_rvalid_i` is high: next cycle `wb_sel_o`=0, `rf_rd_o`=latched rd, `rf_we_o`=`latched_we && rd!=0`; state moves to RUN.
  - A return in the same cycle as the load is accepted is not possible; the earliest legal return is the cycle after acceptance.
- FLUSH:
  - `flush_o` stays high for exactly `FLUSH_CYCLES` cycles, counted from the first flush cycle.
  - `pc_sel_o`=0 only in the first flush cycle, then 1.
  - State returns to RUN after the last flush cycle.
- `mem_rvalid_i` outside LOAD_WAIT is ignored.
- `rd_i`=0 never produces `rf_we_o`=1.
- Outputs hold their last value when no write is issued, except:
  - `rf_we_o`, which is a single-cycle pulse;
  - `pc_sel_o`, which returns to 1.

## Timing
- All outputs except `ins_ready_o` are registered.
- Write-back latency:
  - 1 cycle from the non-load handshake to `rf_we_o`.
  - 1 cycle from `mem_rvalid_i` to `rf_we_o`.
- Redirect latency: 1 cycle from the handshake to `pc_sel_o`=0 and `flush_o`=1.
- Minimum non-load throughput: one instruction per cycle.
- Reset values (applied immediately on `rst` low):
  - state=RUN;
  - `wb_sel_o`=1, `pc_sel_o`=1;
  - `rf_we_o`=0, `rf_rd_o`=0, `flush_o`=0, `err_o`=0;
  - all counters 0.
- Reset during LOAD_WAIT or FLUSH abandons the operation; no write or flush is produced afterwards.
- Counter widths:
  - flush counter: `$clog2(FLUSH_CYCLES+1)` bits;
  - timeout counter: `$clog2(TIMEOUT+1)` bits; saturates and never wraps.

## Configuration
- Macro `WB_CTRL_TIMEOUT_EN`.
- Defined:
  - The LOAD_WAIT counter increments each cycle without `mem_rvalid_i`.
  - When the count reaches `TIMEOUT`, the next cycle sets `err_o`=1 (sticky until reset), suppresses the write (`rf_we_o`=0) and returns to RUN.
  - If `mem_rvalid_i` arrives in the same cycle the count reaches `TIMEOUT`, the data wins: a normal write occurs and `err_o` is unchanged.
- Undefined:
  - No counter is built; LOAD_WAIT waits indefinitely.
  - `err_o` is tied to 0.

## Test plan
- Reset, then ALU op with rd=5, we=1: the cycle after the handshake shows `rf_we_o`=1, `rf_rd_o`=5, `wb_sel_o`=1, `pc_sel_o`=1; `ins_ready_o` stays 1.
- ALU op with rd=0, we=1: `rf_we_o` stays 0.
- Load with rd=7, `mem_rvalid_i` 3 cycles later: `ins_ready_o`=0 for those 3 cycles, then `rf_we_o`=1, `rf_rd_o`=7, `wb_sel_o`=0, and `ins_ready_o`=1 one cycle later.
- Branch with `redirect_i`=1 and `FLUSH_CYCLES`=2: `pc_sel_o`=0 for 1 cycle, `flush_o`=1 for 2 cycles, `ins_ready_o`=0 for 2 cycles, then RUN.
- Reset asserted mid-LOAD_WAIT with `mem_rvalid_i` pulsed after release: outputs hold reset values and no `rf_we_o` pulse occurs.
- With `WB_CTRL_TIMEOUT_EN` and `TIMEOUT`=4, a load with no return: `err_o` rises after 4 wait cycles, no write occurs, `ins_ready_o` returns to 1, and a later ALU op retires normally with `err_o` still 1.
